// File: rtl/var_state_cell.sv
// var_state_cell: per-variable state cell at the bottom of a clause-array
// column. Holds the variable's value, decision level and decided/implied
// status, broadcasts them back up the column, and resolves decision,
// implication, conflict and backtrack under the engine's apply_* strobes.
//
// Optional build macro VAR_STATE_STATS_EN adds saturating implication and
// conflict counters (imp_cnt_o, cfl_cnt_o). Without it the cell is complete
// and those ports do not exist.
module var_state_cell #(
    parameter int WIDTH_LVL = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           var_value_down_i,
    input  logic [WIDTH_LVL-1:0] var_lvl_down_i,
    output logic [2:0]           var_value_o,
    output logic [WIDTH_LVL-1:0] var_lvl_o,
    input  logic                 decide_i,
    input  logic [1:0]           decide_value_i,
    input  logic [WIDTH_LVL-1:0] cur_lvl_i,
    input  logic                 apply_imply_i,
    input  logic                 apply_bkt_i,
    input  logic [WIDTH_LVL-1:0] bkt_lvl_i,
    input  logic                 wr_i,
    input  logic [2:0]           value_wr_i,
    input  logic [WIDTH_LVL-1:0] lvl_wr_i,
    output logic                 imp_new_o,
    output logic                 conflict_o,
    output logic                 assigned_o
`ifdef VAR_STATE_STATS_EN
    ,
    output logic [15:0]          imp_cnt_o,
    output logic [15:0]          cfl_cnt_o
`endif
);

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        DECIDED  = 2'd1,
        IMPLIED  = 2'd2,
        CONFLICT = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           value_r, value_d;
    logic [WIDTH_LVL-1:0] lvl_r, lvl_d;
    logic                 imp_new_r, imp_new_d;
    logic [1:0]           down_pol;

    assign down_pol = var_value_down_i[2:1];

    // Next-state arbitration: wr_i, then backtrack, then decision, then implication.
    always_comb begin
        state_d   = state_q;
        value_d   = value_r;
        lvl_d     = lvl_r;
        imp_new_d = 1'b0;
        if (wr_i) begin
            value_d = value_wr_i;
            lvl_d   = lvl_wr_i;
            if (value_wr_i[2:1] == 2'b00)
                state_d = FREE;
            else if (value_wr_i[2:1] == 2'b11)
                state_d = CONFLICT;
            else if (value_wr_i[0])
                state_d = IMPLIED;
            else
                state_d = DECIDED;
        end else if (apply_bkt_i) begin
            // Only assignments made above the target level are undone.
            if (lvl_r > bkt_lvl_i) begin
                state_d = FREE;
                value_d = 3'b000;
                lvl_d   = '0;
            end
        end else if (decide_i) begin
            if (state_q == FREE) begin
                state_d = DECIDED;
                value_d = {decide_value_i, 1'b0};
                lvl_d   = cur_lvl_i;
            end
        end else if (apply_imply_i) begin
            unique case (state_q)
                FREE: begin
                    if (down_pol == 2'b11) begin
                        state_d = CONFLICT;
                        value_d = 3'b111;
                        lvl_d   = var_lvl_down_i;
                    end else if (down_pol != 2'b00 && var_value_down_i[0]) begin
                        state_d   = IMPLIED;
                        value_d   = {down_pol, 1'b1};
                        lvl_d     = var_lvl_down_i;
                        imp_new_d = 1'b1;
                    end
                end
                DECIDED, IMPLIED: begin
                    // Opposite polarity from the column contradicts our value;
                    // keep the implied bit and level for diagnosis.
                    if (down_pol != 2'b00 && down_pol != value_r[2:1]) begin
                        state_d = CONFLICT;
                        value_d = {2'b11, value_r[0]};
                    end
                end
                default: ;
            endcase
        end
    end

    // State and value registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FREE;
            value_r   <= 3'b000;
            lvl_r     <= '0;
            imp_new_r <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_r   <= value_d;
            lvl_r     <= lvl_d;
            imp_new_r <= imp_new_d;
        end
    end

    assign var_value_o = value_r;
    assign var_lvl_o   = lvl_r;
    assign imp_new_o   = imp_new_r;
    assign conflict_o  = (state_q == CONFLICT);
    assign assigned_o  = (state_q != FREE);

`ifdef VAR_STATE_STATS_EN
    logic [15:0] imp_cnt_r, cfl_cnt_r;
    logic        imp_evt, cfl_evt;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // A wr_i load is a bin swap-in, not an inference event, so it never counts.
    assign imp_evt = !wr_i && (state_q == FREE) && (state_d == IMPLIED);
    assign cfl_evt = !wr_i && (state_q != CONFLICT) && (state_d == CONFLICT);

    // Saturating event counters, cleared on reset and on load.
    always_ff @(posedge clk) begin
        if (!rst || wr_i) begin
            imp_cnt_r <= 16'd0;
            cfl_cnt_r <= 16'd0;
        end else begin
            if (imp_evt) imp_cnt_r <= sat_inc(imp_cnt_r);
            if (cfl_evt) cfl_cnt_r <= sat_inc(cfl_cnt_r);
        end
    end

    assign imp_cnt_o = imp_cnt_r;
    assign cfl_cnt_o = cfl_cnt_r;
`endif

endmodule

// File: tb/tb_var_state_cell.sv
// Testbench for var_state_cell: directed scenarios followed by randomized
// strobes. A driver pushes the reference model's expected outputs into a
// queue; an independent monitor pops one entry per cycle and compares.
module tb_var_state_cell;

    localparam int WL = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    var_value_down_i;
    logic [WL-1:0] var_lvl_down_i;
    logic [2:0]    var_value_o;
    logic [WL-1:0] var_lvl_o;
    logic          decide_i;
    logic [1:0]    decide_value_i;
    logic [WL-1:0] cur_lvl_i;
    logic          apply_imply_i;
    logic          apply_bkt_i;
    logic [WL-1:0] bkt_lvl_i;
    logic          wr_i;
    logic [2:0]    value_wr_i;
    logic [WL-1:0] lvl_wr_i;
    logic          imp_new_o;
    logic          conflict_o;
    logic          assigned_o;
`ifdef VAR_STATE_STATS_EN
    logic [15:0]   imp_cnt_o, cfl_cnt_o;
`endif

    var_state_cell #(.WIDTH_LVL(WL)) dut (
        .clk(clk), .rst(rst),
        .var_value_down_i(var_value_down_i), .var_lvl_down_i(var_lvl_down_i),
        .var_value_o(var_value_o), .var_lvl_o(var_lvl_o),
        .decide_i(decide_i), .decide_value_i(decide_value_i), .cur_lvl_i(cur_lvl_i),
        .apply_imply_i(apply_imply_i), .apply_bkt_i(apply_bkt_i), .bkt_lvl_i(bkt_lvl_i),
        .wr_i(wr_i), .value_wr_i(value_wr_i), .lvl_wr_i(lvl_wr_i),
        .imp_new_o(imp_new_o), .conflict_o(conflict_o), .assigned_o(assigned_o)
`ifdef VAR_STATE_STATS_EN
        , .imp_cnt_o(imp_cnt_o), .cfl_cnt_o(cfl_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    val;
        logic [WL-1:0] lvl;
        logic          imp_new;
        logic          cfl;
        logic          asg;
        logic [15:0]   ic;
        logic [15:0]   cc;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model: status is kept as a name, independent of any encoding.
    string         m_st = "FREE";
    logic [2:0]    m_val = 3'b000;
    logic [WL-1:0] m_lvl = '0;
    logic          m_imp_new = 1'b0;
    int            m_ic = 0, m_cc = 0;

    function automatic void model_step();
        logic [1:0] pol;
        m_imp_new = 1'b0;
        if (!rst) begin
            m_st = "FREE"; m_val = 3'b000; m_lvl = '0; m_ic = 0; m_cc = 0;
            return;
        end
        if (wr_i) begin
            m_val = value_wr_i; m_lvl = lvl_wr_i; m_ic = 0; m_cc = 0;
            case (value_wr_i[2:1])
                2'b00:   m_st = "FREE";
                2'b11:   m_st = "CONFLICT";
                default: m_st = value_wr_i[0] ? "IMPLIED" : "DECIDED";
            endcase
        end else if (apply_bkt_i) begin
            if (int'(m_lvl) > int'(bkt_lvl_i)) begin
                m_st = "FREE"; m_val = 3'b000; m_lvl = '0;
            end
        end else if (decide_i) begin
            if (m_st == "FREE") begin
                m_st = "DECIDED"; m_val = {decide_value_i, 1'b0}; m_lvl = cur_lvl_i;
            end
        end else if (apply_imply_i) begin
            pol = var_value_down_i[2:1];
            if (m_st == "FREE") begin
                if (pol == 2'b11) begin
                    m_st = "CONFLICT"; m_val = 3'b111; m_lvl = var_lvl_down_i;
                    if (m_cc < 65535) m_cc++;
                end else if (pol != 2'b00 && var_value_down_i[0]) begin
                    m_st = "IMPLIED"; m_val = {pol, 1'b1}; m_lvl = var_lvl_down_i;
                    m_imp_new = 1'b1;
                    if (m_ic < 65535) m_ic++;
                end
            end else if (m_st != "CONFLICT") begin
                if (pol != 2'b00 && pol != m_val[2:1]) begin
                    m_st = "CONFLICT"; m_val[2:1] = 2'b11;
                    if (m_cc < 65535) m_cc++;
                end
            end
        end
    endfunction

    task automatic drive(input logic r, input logic wr, input logic [2:0] vw,
                         input logic [WL-1:0] lw, input logic bkt, input logic [WL-1:0] bl,
                         input logic dec, input logic [1:0] dv, input logic [WL-1:0] cl,
                         input logic imp, input logic [2:0] dn, input logic [WL-1:0] ld);
        exp_t e;
        @(negedge clk);
        rst = r; wr_i = wr; value_wr_i = vw; lvl_wr_i = lw;
        apply_bkt_i = bkt; bkt_lvl_i = bl;
        decide_i = dec; decide_value_i = dv; cur_lvl_i = cl;
        apply_imply_i = imp; var_value_down_i = dn; var_lvl_down_i = ld;
        model_step();
        e.val = m_val; e.lvl = m_lvl; e.imp_new = m_imp_new;
        e.cfl = (m_st == "CONFLICT"); e.asg = (m_st != "FREE");
        e.ic = 16'(m_ic); e.cc = 16'(m_cc);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(1, 0, 3'b0, '0, 0, '0, 0, 2'b0, '0, 0, 3'b0, '0);
    endtask
    task automatic do_reset();
        drive(0, 0, 3'b0, '0, 0, '0, 0, 2'b0, '0, 0, 3'b0, '0);
    endtask
    task automatic do_decide(input logic [1:0] dv, input logic [WL-1:0] cl);
        drive(1, 0, 3'b0, '0, 0, '0, 1, dv, cl, 0, 3'b0, '0);
    endtask
    task automatic do_imply(input logic [2:0] dn, input logic [WL-1:0] ld);
        drive(1, 0, 3'b0, '0, 0, '0, 0, 2'b0, '0, 1, dn, ld);
    endtask
    task automatic do_bkt(input logic [WL-1:0] bl);
        drive(1, 0, 3'b0, '0, 1, bl, 0, 2'b0, '0, 0, 3'b0, '0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the cell presents a result every cycle, one after each driven edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("var_value", 32'(var_value_o), 32'(e.val));
            chk("var_lvl",   32'(var_lvl_o),   32'(e.lvl));
            chk("imp_new",   32'(imp_new_o),   32'(e.imp_new));
            chk("conflict",  32'(conflict_o),  32'(e.cfl));
            chk("assigned",  32'(assigned_o),  32'(e.asg));
`ifdef VAR_STATE_STATS_EN
            chk("imp_cnt",   32'(imp_cnt_o),   32'(e.ic));
            chk("cfl_cnt",   32'(cfl_cnt_o),   32'(e.cc));
`endif
        end
    end

    initial begin
        int r;
        rst = 0; wr_i = 0; value_wr_i = 0; lvl_wr_i = 0; apply_bkt_i = 0; bkt_lvl_i = 0;
        decide_i = 0; decide_value_i = 0; cur_lvl_i = 0; apply_imply_i = 0;
        var_value_down_i = 0; var_lvl_down_i = 0;

        do_reset(); do_reset();
        // Decision from FREE
        do_decide(2'b10, 16'd3); idle();
        // Implication from FREE, imp_new pulse then drop
        do_reset(); do_imply(3'b011, 16'd5); idle(); idle();
        // Conflict against a decision; later decision ignored
        do_reset(); do_decide(2'b10, 16'd2); do_imply(3'b011, 16'd9);
        do_decide(2'b01, 16'd6); do_imply(3'b101, 16'd1); idle();
        // Backtrack boundary: equal level holds, lower target frees
        do_reset(); do_imply(3'b011, 16'd4); do_bkt(16'd4); do_bkt(16'd3); idle();
        // Level-0 assignment survives bkt 0
        do_decide(2'b01, 16'd0); do_bkt(16'd0);
        // wr_i beats same-cycle backtrack
        drive(1, 1, 3'b101, 16'd7, 1, 16'd0, 0, 2'b0, '0, 0, 3'b0, '0); idle();
        // Implied bit without polarity, and direct conflict from FREE
        do_reset(); do_imply(3'b001, 16'd2); do_imply(3'b010, 16'd2); do_imply(3'b111, 16'd8);
        do_bkt(16'd8); do_bkt(16'd7); idle();
        // Three implications and one conflict, then a clearing load
        do_imply(3'b011, 16'd4); do_bkt(16'd0); do_imply(3'b101, 16'd4); do_bkt(16'd0);
        do_imply(3'b011, 16'd4); do_imply(3'b101, 16'd4); idle();
        drive(1, 1, 3'b000, 16'd0, 0, '0, 0, 2'b0, '0, 0, 3'b0, '0); idle();

        // Randomized strobes; decide and imply never coincide
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 49);
            if (r == 0)
                do_reset();
            else if (r < 5)
                drive(1, 1, 3'($urandom), 16'($urandom_range(0, 7)), 1'($urandom),
                      16'($urandom_range(0, 7)), 0, 2'b0, '0, 0, 3'($urandom), 16'($urandom));
            else if (r < 13)
                do_bkt(16'($urandom_range(0, 7)));
            else if (r < 23)
                drive(1, 0, 3'b0, '0, 0, '0, 1, ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01,
                      16'($urandom_range(0, 7)), 0, 3'($urandom), 16'($urandom));
            else if (r < 45)
                do_imply(3'($urandom), 16'($urandom_range(0, 7)));
            else
                idle();
        end

        // Bounded drain of the scoreboard
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
